// File: rtl/gbf_fill_scheduler.sv
// Round-robin refill scheduler: four GBF need_data requests share one burst read port, and each burst streams GBF_DEPTH lines into the granted buffer.
// Defining GBF_FILL_PERF_EN adds the stall_cycles output: it counts cycles spent waiting for a grant or for read data.
module gbf_fill_scheduler #(
  parameter int GBF_DATA_BITWIDTH = 256,
  parameter int GBF_ADDR_BITWIDTH = 5,
  parameter int GBF_DEPTH         = 32,
  parameter int MEM_ADDR_BITWIDTH = 32,
  parameter int ACTV_BASE         = 0,
  parameter int WGT_BASE          = 4096,
  parameter int ACTV_TILES        = 8,
  parameter int WGT_TILES         = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   need_data,
  output logic [3:0]                   gbf_en,
  output logic [3:0]                   gbf_we,
  output logic [GBF_ADDR_BITWIDTH-1:0] gbf_addr,
  output logic [GBF_DATA_BITWIDTH-1:0] gbf_w_data,
  output logic [3:0]                   buf_ready,
  output logic                         gbf_actv_data_avail,
  output logic                         gbf_wgt_data_avail,
  output logic                         finish,
`ifdef GBF_FILL_PERF_EN
  output logic [31:0]                  stall_cycles,
`endif
  output logic                         mem_rd_req,
  output logic [MEM_ADDR_BITWIDTH-1:0] mem_rd_addr,
  input  logic                         mem_rd_gnt,
  input  logic                         mem_rd_valid,
  input  logic [GBF_DATA_BITWIDTH-1:0] mem_rd_data
);

  localparam int AW = MEM_ADDR_BITWIDTH;
  localparam int BW = GBF_ADDR_BITWIDTH;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             pend_q, pend_d;
  logic [3:0]             need_prev_q;
  logic [1:0]             tgt_q, tgt_d;
  logic [1:0]             rr_q, rr_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [AW-1:0]          actv_cnt_q, actv_cnt_d;
  logic [AW-1:0]          wgt_cnt_q, wgt_cnt_d;
  logic [3:0]             gbf_en_q, gbf_en_d;
  logic [BW-1:0]          gbf_addr_q, gbf_addr_d;
  logic [GBF_DATA_BITWIDTH-1:0] gbf_w_data_q, gbf_w_data_d;
  logic [3:0]             buf_ready_q, buf_ready_d;
  logic                   actv_avail_q, actv_avail_d;
  logic                   wgt_avail_q, wgt_avail_d;
  logic                   finish_q, finish_d;
  logic                   mem_rd_req_q, mem_rd_req_d;
  logic [AW-1:0]          mem_rd_addr_q, mem_rd_addr_d;

  logic                   actv_done, wgt_done;
  logic [3:0]             elig, cap;
  logic                   gnt_found;
  logic [1:0]             gnt_idx, idx;

  assign actv_done = (actv_cnt_q >= AW'(ACTV_TILES));
  assign wgt_done  = (wgt_cnt_q >= AW'(WGT_TILES));
  assign elig      = pend_q & {{2{~wgt_done}}, {2{~actv_done}}};

  // First eligible request at or after the round-robin pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_q;
    idx       = rr_q;
    for (int k = 0; k < 4; k++) begin
      idx = rr_q + 2'(k);
      if (!gnt_found && elig[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    tgt_d         = tgt_q;
    rr_d          = rr_q;
    beat_d        = beat_q;
    actv_cnt_d    = actv_cnt_q;
    wgt_cnt_d     = wgt_cnt_q;
    buf_ready_d   = buf_ready_q;
    actv_avail_d  = actv_avail_q;
    wgt_avail_d   = wgt_avail_q;
    finish_d      = finish_q;
    mem_rd_req_d  = mem_rd_req_q;
    mem_rd_addr_d = mem_rd_addr_q;
    gbf_en_d      = '0;
    gbf_addr_d    = gbf_addr_q;
    gbf_w_data_d  = gbf_w_data_q;

    cap = need_data & ~need_prev_q;
    if (state_q != S_IDLE) cap[tgt_q] = 1'b0;
    if (finish_q) cap = '0;
    pend_d = pend_q | cap;
    if (actv_done) pend_d[1:0] = '0;
    if (wgt_done)  pend_d[3:2] = '0;

    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          state_d              = S_REQ;
          tgt_d                = gnt_idx;
          rr_d                 = gnt_idx + 2'd1;
          pend_d[gnt_idx]      = 1'b0;
          buf_ready_d[gnt_idx] = 1'b0;
          mem_rd_req_d         = 1'b1;
          mem_rd_addr_d        = gnt_idx[1] ? AW'(WGT_BASE) + wgt_cnt_q * AW'(GBF_DEPTH)
                                            : AW'(ACTV_BASE) + actv_cnt_q * AW'(GBF_DEPTH);
        end
      end
      S_REQ: begin
        if (mem_rd_gnt) begin
          state_d      = S_FILL;
          mem_rd_req_d = 1'b0;
          beat_d       = '0;
        end
      end
      S_FILL: begin
        if (mem_rd_valid) begin
          gbf_en_d     = 4'b0001 << tgt_q;
          gbf_addr_d   = beat_q;
          gbf_w_data_d = mem_rd_data;
          if (beat_q == BW'(GBF_DEPTH - 1)) begin
            beat_d  = '0;
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      S_DONE: begin
        state_d            = S_IDLE;
        buf_ready_d[tgt_q] = 1'b1;
        if (tgt_q[1]) begin
          wgt_cnt_d   = wgt_cnt_q + AW'(1);
          wgt_avail_d = (wgt_cnt_d < AW'(WGT_TILES));
        end else begin
          actv_cnt_d   = actv_cnt_q + AW'(1);
          actv_avail_d = (actv_cnt_d < AW'(ACTV_TILES));
        end
        finish_d = finish_q | ((actv_cnt_d == AW'(ACTV_TILES)) && (wgt_cnt_d == AW'(WGT_TILES)));
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pend_q        <= '0;
      need_prev_q   <= '0;
      tgt_q         <= '0;
      rr_q          <= '0;
      beat_q        <= '0;
      actv_cnt_q    <= '0;
      wgt_cnt_q     <= '0;
      gbf_en_q      <= '0;
      gbf_addr_q    <= '0;
      gbf_w_data_q  <= '0;
      buf_ready_q   <= '0;
      actv_avail_q  <= 1'b1;
      wgt_avail_q   <= 1'b1;
      finish_q      <= 1'b0;
      mem_rd_req_q  <= 1'b0;
      mem_rd_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      need_prev_q   <= need_data;
      tgt_q         <= tgt_d;
      rr_q          <= rr_d;
      beat_q        <= beat_d;
      actv_cnt_q    <= actv_cnt_d;
      wgt_cnt_q     <= wgt_cnt_d;
      gbf_en_q      <= gbf_en_d;
      gbf_addr_q    <= gbf_addr_d;
      gbf_w_data_q  <= gbf_w_data_d;
      buf_ready_q   <= buf_ready_d;
      actv_avail_q  <= actv_avail_d;
      wgt_avail_q   <= wgt_avail_d;
      finish_q      <= finish_d;
      mem_rd_req_q  <= mem_rd_req_d;
      mem_rd_addr_q <= mem_rd_addr_d;
    end
  end

`ifdef GBF_FILL_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (!finish_q && (stall_q != '1) &&
        ((state_q == S_REQ) || ((state_q == S_FILL) && !mem_rd_valid)))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

  assign gbf_en              = gbf_en_q;
  assign gbf_we              = gbf_en_q;
  assign gbf_addr            = gbf_addr_q;
  assign gbf_w_data          = gbf_w_data_q;
  assign buf_ready           = buf_ready_q;
  assign gbf_actv_data_avail = actv_avail_q;
  assign gbf_wgt_data_avail  = wgt_avail_q;
  assign finish              = finish_q;
  assign mem_rd_req          = mem_rd_req_q;
  assign mem_rd_addr         = mem_rd_addr_q;

endmodule
